// File: rtl/apb_slave_mem.sv
// APB responder with a 16-word register file, optional wait states, an error
// response for out-of-window or misaligned addresses, and a good-write counter.
module apb_slave_mem #(
    parameter int          SEL_BIT     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  wr_count
);

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [3:0]  idx_q;
    logic        write_q;
    logic        hit_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [16];

    logic sel;
    logic hit_in;
    logic unused_psel;

    always_comb begin
        sel         = psel[SEL_BIT];
        hit_in      = (paddr[31:6] == BASE_ADDR[31:6]) && (paddr[1:0] == 2'b00);
        unused_psel = ^psel;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hit_q    <= 1'b0;
            wdata_q  <= '0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            wr_count <= '0;
            for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && !penable) begin
                        state   <= ACCESS;
                        idx_q   <= paddr[5:2];
                        write_q <= pwrite;
                        hit_q   <= hit_in;
                        wdata_q <= pwdata;
                        cnt     <= WS;
                        // Zero wait states: respond on the setup edge so data is
                        // valid throughout the bridge's penable cycle.
                        if (WS == 2'd0) begin
                            pready  <= 1'b1;
                            pslverr <= !hit_in;
                            if (!pwrite) prdata <= hit_in ? mem[paddr[5:2]] : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!sel) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (penable) begin
                        if (pready) begin
                            state   <= IDLE;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            if (write_q && hit_q) begin
                                mem[idx_q] <= wdata_q;
                                wr_count   <= wr_count + 8'd1;
                            end
                        end else begin
                            cnt <= cnt - 2'd1;
                            if (cnt == 2'd1) begin
                                pready  <= 1'b1;
                                pslverr <= !hit_q;
                                if (!write_q) prdata <= hit_q ? mem[idx_q] : '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Three responders share one APB bus on different psel bits with 0, 2 and 3
// wait states; directed vectors plus abort, wrap and reset sequences.
module tb_apb_slave_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;
    logic [7:0]  wr_count_v [3];

    int checks = 0;
    int errors = 0;
    int stray  = 0;

    always #5 hclk = ~hclk;

    apb_slave_mem #(.SEL_BIT(0), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_s0 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .wr_count(wr_count_v[0]));
    apb_slave_mem #(.SEL_BIT(1), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(2)) u_s1 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .wr_count(wr_count_v[1]));
    apb_slave_mem #(.SEL_BIT(2), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) u_s2 (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]), .wr_count(wr_count_v[2]));

    // An unselected responder must never raise pready.
    always @(negedge hclk) begin
        for (int i = 0; i < 3; i++)
            if (pready_v[i] && !psel[i]) stray++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string name);
        for (int i = 0; i < 3; i++) begin
            chk({name, " prdata"},   prdata_v[i], 32'h0);
            chk({name, " pready"},   {31'b0, pready_v[i]}, 32'h0);
            chk({name, " pslverr"},  {31'b0, pslverr_v[i]}, 32'h0);
            chk({name, " wr_count"}, {24'b0, wr_count_v[i]}, 32'h0);
        end
    endtask

    task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits);
        @(posedge hclk); #1;
        psel = 3'(1 << s); penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        pwrite = ~w; paddr = 32'hFFFF_FFFF; pwdata = 32'h5A5A_5A5A;
        waits = 0;
        while (!pready_v[s] && waits < 8) begin
            @(posedge hclk); #1;
            waits++;
        end
        if (!pready_v[s]) begin
            checks++; errors++;
            $display("FAIL pready_timeout: slave %0d no pready after %0d cycles", s, waits);
            rd = 'x; err = 1'bx;
        end else begin
            rd = prdata_v[s]; err = pslverr_v[s];
        end
        @(posedge hclk); #1;
        chk("pready_clears", {31'b0, pready_v[s]}, 32'h0);
        psel = '0; penable = 1'b0;
    endtask

    typedef struct {
        int          s;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic [7:0]  wc;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] rd;
    logic        err;
    int          waits;

    initial begin
        tbl[0] = '{0, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 8'd1};
        tbl[1] = '{0, 1'b0, 32'h8000_0014, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 8'd1};
        tbl[2] = '{0, 1'b1, 32'h9000_0000, 32'h0000_1234, 32'h0,         1'b1, 0, 8'd1};
        tbl[3] = '{0, 1'b0, 32'h8000_0002, 32'h0,         32'h0,         1'b1, 0, 8'd1};
        tbl[4] = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 0, 8'd1};
        tbl[5] = '{0, 1'b0, 32'h8000_0014, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 8'd1};
        tbl[6] = '{1, 1'b1, 32'h8000_003C, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 8'd1};
        tbl[7] = '{1, 1'b0, 32'h8000_003C, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 8'd1};
        tbl[8] = '{2, 1'b1, 32'h8000_0008, 32'h0000_0055, 32'h0,         1'b0, 3, 8'd1};
        tbl[9] = '{2, 1'b0, 32'h8000_0008, 32'h0,         32'h0000_0055, 1'b0, 3, 8'd1};

        hreset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk_reset_state("reset");
        hreset = 1'b0;

        // penable alone in IDLE must not start a transfer.
        penable = 1'b1; psel = 3'b001;
        @(posedge hclk); #1;
        chk("penable_in_idle", {31'b0, pready_v[0]}, 32'h0);
        psel = '0; penable = 1'b0;

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, rd, err, waits);
            if (!tbl[i].w) chk($sformatf("vec%0d prdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d pslverr", i), {31'b0, err}, {31'b0, tbl[i].err});
            chk($sformatf("vec%0d waits", i), 32'(waits), 32'(tbl[i].waits));
            chk($sformatf("vec%0d wr_count", i), {24'b0, wr_count_v[tbl[i].s]}, {24'b0, tbl[i].wc});
        end

        // Abort on slave 2 before pready: no write, counter unchanged.
        @(posedge hclk); #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0010; pwdata = 32'h0000_AAAA;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        psel = '0; penable = 1'b0;
        @(posedge hclk); #1;
        chk("abort pready", {31'b0, pready_v[2]}, 32'h0);
        chk("abort wr_count", {24'b0, wr_count_v[2]}, 32'h1);
        xfer(2, 1'b0, 32'h8000_0010, 32'h0, rd, err, waits);
        chk("abort no write", rd, 32'h0);
        chk("abort then waits", 32'(waits), 32'd3);

        // 255 more good writes on slave 0 bring the count from 1 around to 0.
        for (int i = 0; i < 255; i++)
            xfer(0, 1'b1, 32'h8000_0000 + 32'((i % 16) * 4), 32'(i), rd, err, waits);
        chk("wrap wr_count", {24'b0, wr_count_v[0]}, 32'h0);
        xfer(0, 1'b0, 32'h8000_003C, 32'h0, rd, err, waits);
        chk("wrap mem15", rd, 32'd239);

        // Reset while slave 1 is mid-access on a write.
        @(posedge hclk); #1;
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_003C; pwdata = 32'h1111_1111;
        @(posedge hclk); #1;
        penable = 1'b1; hreset = 1'b1;
        @(posedge hclk); #1;
        chk_reset_state("midreset");
        hreset = 1'b0; psel = '0; penable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b0, 32'h8000_0000 + 32'(i * 4), 32'h0, rd, err, waits);
            chk($sformatf("reset mem%0d", i), rd, 32'h0);
        end
        xfer(1, 1'b0, 32'h8000_003C, 32'h0, rd, err, waits);
        chk("reset dropped write", rd, 32'h0);

        chk("select isolation", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
